imem_dmem_arbiter: RTL

- Sequences a single-port unified memory shared by the CPU instruction-fetch port and the MEM-stage data port.
- Accepts level-held requests from both requesters and grants one at a time.
- Drives the memory-side control, waits the fixed read latency and returns data with a one-cycle ready pulse.
- Sits between the `top` core's IMem/DMem ports and the unified memory model; requesters stall while their request is pending.

---
 rtl/imem_dmem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sequencing a single-port unified memory between instruction fetch and data access.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module imem_dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [1:0]        grant_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic              pick_data_d;

`ifdef ARB_RR_EN
    // last_owner_q = 1 means data was served last, so fetch wins the next tie.
    logic last_owner_q;
    always_comb pick_data_d = d_req && (!i_req || !last_owner_q);
`else
    always_comb pick_data_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    grant_q <= 2'b00;
                    if (i_req || d_req) begin
                        state_q  <= ISSUE;
                        mem_en_q <= 1'b1;
                        if (pick_data_d) begin
                            grant_q     <= 2'b10;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            grant_q    <= 2'b01;
                            mem_addr_q <= i_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we_q) begin
                        d_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (MEM_LAT == 1) begin
                        if (grant_q[1]) begin
                            d_rdata_q <= mem_rdata;
                            d_ready_q <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_rdata;
                            i_ready_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (grant_q[1]) begin
                            d_rdata_q <= mem_rdata;
                            d_ready_q <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_rdata;
                            i_ready_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
`ifdef ARB_RR_EN
                    last_owner_q <= grant_q[1];
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;

endmodule
